// File: rtl/parser_lit_arbiter.sv
// Round-robin reader that drains NUM_REQ literal FIFOs into one valid/ready stream tagged with source index.
// Read issue to lit_valid is 2 cycles; with lit_ready low, issue stops once queued plus in-flight entries reach 2.
module parser_lit_arbiter #(
  parameter int WIDTH   = 85,
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [NUM_REQ-1:0]       fifo_empty_i,
  output logic [NUM_REQ-1:0]       fifo_rd_en_o,
  input  logic [NUM_REQ*WIDTH-1:0] fifo_dout_i,
  output logic                     lit_valid_o,
  output logic [WIDTH-1:0]         lit_data_o,
  output logic [SRC_W-1:0]         lit_src_o,
  input  logic                     lit_ready_i,
  output logic                     busy_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SRC_W-1:0] src;
  } entry_t;

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             inflight_q, inflight_d;
  logic [SRC_W-1:0] inflight_src_q, inflight_src_d;
  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             lit_valid_q, lit_valid_d;
  logic [WIDTH-1:0] lit_data_q, lit_data_d;
  logic [SRC_W-1:0] lit_src_q, lit_src_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] dout_arr [NUM_REQ];
  logic             pop;
  logic [2:0]       pending;
  logic             issue;
  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_dout
    assign dout_arr[i] = fifo_dout_i[i*WIDTH +: WIDTH];
  end

  assign pop = lit_valid_q & lit_ready_i;

  // First non-empty requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(NUM_REQ)) begin
        sum = sum - (SRC_W+1)'(NUM_REQ);
      end
      idx = sum[SRC_W-1:0];
      if (!grant_vld && !fifo_empty_i[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Slots already committed after this cycle's pop; a read is only issued when one is free.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = !srst_i && grant_vld && (pending < 3'd2);

  always_comb begin
    fifo_rd_en_o = '0;
    if (issue) begin
      fifo_rd_en_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    mem_d          = mem_q;
    head_d         = head_q;
    tail_d         = tail_q;
    rr_ptr_d       = rr_ptr_q;
    inflight_d     = issue;
    inflight_src_d = inflight_src_q;

    if (issue) begin
      inflight_src_d = grant_idx;
      rr_ptr_d       = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    if (inflight_q) begin
      mem_d[tail_q] = {dout_arr[inflight_src_q], inflight_src_q};
      tail_d        = ~tail_q;
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    lit_valid_d = (occ_d != 2'd0);
    lit_data_d  = mem_d[head_d].data;
    lit_src_d   = mem_d[head_d].src;
    busy_d      = inflight_d | (occ_d != 2'd0);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rr_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_src_q <= '0;
      mem_q[0]       <= '0;
      mem_q[1]       <= '0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      occ_q          <= '0;
      lit_valid_q    <= 1'b0;
      lit_data_q     <= '0;
      lit_src_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
      mem_q[0]       <= mem_d[0];
      mem_q[1]       <= mem_d[1];
      head_q         <= head_d;
      tail_q         <= tail_d;
      occ_q          <= occ_d;
      lit_valid_q    <= lit_valid_d;
      lit_data_q     <= lit_data_d;
      lit_src_q      <= lit_src_d;
      busy_q         <= busy_d;
    end
  end

  assign lit_valid_o = lit_valid_q;
  assign lit_data_o  = lit_data_q;
  assign lit_src_o   = lit_src_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_parser_lit_arbiter.sv
// Bench for parser_lit_arbiter: queue-based FIFO environment plus a transaction-level reference model.
module tb_parser_lit_arbiter;
  localparam int W = 85;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk_i = 1'b0;
  logic           srst_i;
  logic [N-1:0]   fifo_empty_i;
  logic [N-1:0]   fifo_rd_en_o;
  logic [N*W-1:0] fifo_dout_i;
  logic           lit_valid_o;
  logic [W-1:0]   lit_data_o;
  logic [S-1:0]   lit_src_o;
  logic           lit_ready_i;
  logic           busy_o;

  parser_lit_arbiter #(.WIDTH(W), .NUM_REQ(N), .SRC_W(S)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_dout_i(fifo_dout_i), .lit_valid_o(lit_valid_o), .lit_data_o(lit_data_o),
    .lit_src_o(lit_src_o), .lit_ready_i(lit_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } ent_t;

  logic [W-1:0] fq [N][$];
  logic [W-1:0] dout_arr [N];
  ent_t         outq [$];
  int           m_rr;
  bit           m_inf;
  int           m_inf_src;
  logic [W-1:0] m_inf_data;

  int           checks = 0;
  int           errors = 0;
  int           rd_pulses;
  logic [N-1:0] last_rd;
  logic         last_valid;
  logic [W-1:0] last_data;
  logic [S-1:0] last_src;

  always_comb begin
    for (int i = 0; i < N; i++) fifo_dout_i[i*W +: W] = dout_arr[i];
  end

  function automatic logic [W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // One clock cycle: compare DUT against the model before the edge, then advance FIFOs and model.
  task automatic step(input bit chk);
    bit           pop, issue;
    int           g, pend, idx;
    logic [N-1:0] exp_rd;
    logic [W-1:0] nd;
    for (int i = 0; i < N; i++) fifo_empty_i[i] = (fq[i].size() == 0);
    #1;
    pop = (outq.size() != 0) && lit_ready_i;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (g < 0 && fq[idx].size() != 0) g = idx;
    end
    pend  = outq.size() + int'(m_inf) - int'(pop);
    issue = !srst_i && (g >= 0) && (pend < 2);
    exp_rd = '0;
    nd = '0;
    if (issue) begin
      exp_rd[g] = 1'b1;
      nd = fq[g][0];
    end
    if (chk) begin
      checks++;
      if (fifo_rd_en_o !== exp_rd) begin
        errors++; $display("FAIL rd_en: got %b expected %b", fifo_rd_en_o, exp_rd);
      end
      checks++;
      if ((fifo_rd_en_o & fifo_empty_i) !== '0) begin
        errors++; $display("FAIL rd_underflow: rd_en %b while empty %b, required no overlap", fifo_rd_en_o, fifo_empty_i);
      end
      checks++;
      if (lit_valid_o !== (outq.size() != 0)) begin
        errors++; $display("FAIL lit_valid: got %b expected %b", lit_valid_o, outq.size() != 0);
      end
      if (outq.size() != 0) begin
        checks++;
        if (lit_data_o !== outq[0].d || lit_src_o !== S'(outq[0].s)) begin
          errors++;
          $display("FAIL lit_beat: got %h/%0d expected %h/%0d", lit_data_o, lit_src_o, outq[0].d, outq[0].s);
        end
      end
      checks++;
      if (busy_o !== (m_inf || outq.size() != 0)) begin
        errors++; $display("FAIL busy: got %b expected %b", busy_o, m_inf || outq.size() != 0);
      end
    end
    last_rd    = fifo_rd_en_o;
    last_valid = lit_valid_o;
    last_data  = lit_data_o;
    last_src   = lit_src_o;
    rd_pulses += $countones(fifo_rd_en_o);
    @(posedge clk_i);
    #1;
    if (srst_i) begin
      for (int i = 0; i < N; i++) begin
        fq[i].delete();
        dout_arr[i] = rnd();
      end
      outq.delete();
      m_rr = 0;
      m_inf = 0;
      m_inf_src = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (last_rd[i] && fq[i].size() != 0) dout_arr[i] = fq[i].pop_front();
        else dout_arr[i] = rnd();
      end
      if (pop) void'(outq.pop_front());
      if (m_inf) outq.push_back('{d: m_inf_data, s: m_inf_src});
      m_inf = issue;
      if (issue) begin
        m_inf_src  = g;
        m_inf_data = nd;
        m_rr       = (g + 1) % N;
      end
    end
  endtask

  task automatic do_reset();
    srst_i = 1'b1;
    step(1);
    srst_i = 1'b0;
  endtask

  task automatic test_reset();
    fq[1].push_back(rnd());
    lit_ready_i = 1'b1;
    do_reset();
    checks++;
    if (lit_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid %b busy %b, required 0 0", lit_valid_o, busy_o);
    end
    checks++;
    if (lit_data_o !== '0 || lit_src_o !== '0) begin
      errors++; $display("FAIL reset_data: data %h src %0d, required 0 0", lit_data_o, lit_src_o);
    end
    checks++;
    if (last_rd !== '0) begin
      errors++; $display("FAIL reset_rd_gate: rd_en %b during srst, required 0", last_rd);
    end
  endtask

  task automatic test_single_fifo();
    logic [W-1:0] a, b;
    logic [N-1:0] rd_seq [6];
    logic         v_seq [6];
    logic [W-1:0] d_seq [6];
    logic [S-1:0] s_seq [6];
    do_reset();
    lit_ready_i = 1'b1;
    a = rnd(); b = rnd();
    fq[2].push_back(a);
    fq[2].push_back(b);
    for (int t = 0; t < 6; t++) begin
      step(1);
      rd_seq[t] = last_rd; v_seq[t] = last_valid; d_seq[t] = last_data; s_seq[t] = last_src;
    end
    checks++;
    if (rd_seq[0] !== 4'b0100 || rd_seq[1] !== 4'b0100 || rd_seq[2] !== 4'b0000) begin
      errors++; $display("FAIL single_rd: got %b %b %b expected 0100 0100 0000", rd_seq[0], rd_seq[1], rd_seq[2]);
    end
    checks++;
    if (v_seq[1] !== 1'b0 || v_seq[2] !== 1'b1 || d_seq[2] !== a || s_seq[2] !== 2'd2) begin
      errors++; $display("FAIL single_first: valid %b/%b data %h src %0d expected 0/1 %h 2", v_seq[1], v_seq[2], d_seq[2], s_seq[2], a);
    end
    checks++;
    if (v_seq[3] !== 1'b1 || d_seq[3] !== b || s_seq[3] !== 2'd2 || v_seq[4] !== 1'b0) begin
      errors++; $display("FAIL single_second: valid %b data %h src %0d then %b expected 1 %h 2 then 0", v_seq[3], d_seq[3], s_seq[3], v_seq[4], b);
    end
  endtask

  task automatic test_all_fifos();
    int srcs [$];
    int first_t, last_t;
    do_reset();
    lit_ready_i = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) fq[i].push_back(rnd());
    first_t = -1; last_t = -1;
    for (int t = 0; t < 20; t++) begin
      step(1);
      if (last_valid) begin
        srcs.push_back(int'(last_src));
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    checks++;
    if (srcs.size() != 12 || (last_t - first_t) != 11) begin
      errors++; $display("FAIL rr_beats: got %0d beats over span %0d expected 12 over 11", srcs.size(), last_t - first_t);
    end
    for (int k = 0; k < srcs.size() && k < 12; k++) begin
      checks++;
      if (srcs[k] != k % N) begin
        errors++; $display("FAIL rr_order: beat %0d src %0d expected %0d", k, srcs[k], k % N);
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] r0, r1;
    do_reset();
    lit_ready_i = 1'b1;
    fq[1].push_back(rnd());
    for (int t = 0; t < 6; t++) step(1);
    fq[1].push_back(rnd());
    fq[3].push_back(rnd());
    step(1); r0 = last_rd;
    step(1); r1 = last_rd;
    checks++;
    if (r0 !== 4'b1000 || r1 !== 4'b0010) begin
      errors++; $display("FAIL wrap: grants %b %b expected 1000 0010", r0, r1);
    end
    for (int t = 0; t < 5; t++) step(1);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rds [$];
    logic [W-1:0] held;
    bit           have;
    do_reset();
    lit_ready_i = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) fq[i].push_back(rnd());
    rd_pulses = 0;
    have = 0;
    held = '0;
    for (int t = 0; t < 6; t++) begin
      step(1);
      if (last_rd != '0) rds.push_back(last_rd);
      if (last_valid) begin
        if (have) begin
          checks++;
          if (last_data !== held) begin
            errors++; $display("FAIL bp_stable: data %h expected %h", last_data, held);
          end
        end
        held = last_data;
        have = 1;
      end
    end
    checks++;
    if (rd_pulses != 2 || rds.size() != 2) begin
      errors++; $display("FAIL bp_count: %0d rd pulses expected 2", rd_pulses);
    end else begin
      checks++;
      if (rds[0] !== 4'b0001 || rds[1] !== 4'b0010) begin
        errors++; $display("FAIL bp_order: %b %b expected 0001 0010", rds[0], rds[1]);
      end
    end
    lit_ready_i = 1'b1;
    step(1);
    checks++;
    if (last_rd !== 4'b0100) begin
      errors++; $display("FAIL bp_resume: rd_en %b expected 0100", last_rd);
    end
    for (int t = 0; t < 16; t++) step(1);
  endtask

  task automatic test_one_entry();
    do_reset();
    lit_ready_i = 1'b1;
    fq[0].push_back(rnd());
    rd_pulses = 0;
    for (int t = 0; t < 8; t++) step(1);
    checks++;
    if (rd_pulses != 1) begin
      errors++; $display("FAIL one_entry: %0d rd pulses expected 1", rd_pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lit_ready_i = 1'b0;
    fq[1].push_back(rnd());
    step(1);
    step(1);
    fq[2].push_back(rnd());
    step(1);
    fq[3].push_back(rnd());
    srst_i = 1'b1;
    step(1);
    srst_i = 1'b0;
    checks++;
    if (last_rd !== '0) begin
      errors++; $display("FAIL mid_rd_gate: rd_en %b during srst, required 0", last_rd);
    end
    checks++;
    if (lit_valid_o !== 1'b0 || busy_o !== 1'b0 || fifo_rd_en_o !== '0) begin
      errors++; $display("FAIL mid_clear: valid %b busy %b rd %b, required 0 0 0", lit_valid_o, busy_o, fifo_rd_en_o);
    end
    fq[0].push_back(rnd());
    fq[3].push_back(rnd());
    step(1);
    checks++;
    if (last_rd !== 4'b0001) begin
      errors++; $display("FAIL mid_restart: rd_en %b expected 0001", last_rd);
    end
    lit_ready_i = 1'b1;
    for (int t = 0; t < 6; t++) step(1);
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      lit_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) fq[i].push_back(rnd());
      srst_i = ($urandom_range(0, 79) == 0);
      step(1);
    end
    srst_i = 1'b0;
    lit_ready_i = 1'b1;
    for (int t = 0; t < 60; t++) step(1);
  endtask

  initial begin
    srst_i = 1'b1;
    lit_ready_i = 1'b0;
    fifo_empty_i = '1;
    rd_pulses = 0;
    m_rr = 0; m_inf = 0; m_inf_src = 0; m_inf_data = '0;
    for (int i = 0; i < N; i++) dout_arr[i] = '0;
    step(0);
    step(0);
    test_reset();
    test_single_fifo();
    test_all_fifos();
    test_wrap();
    test_backpressure();
    test_one_entry();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
